// File: rtl/mru_pkg.sv
// Shared helpers for the MRU tracker: index-width computation.
package mru_pkg;

    // Number of bits needed to address depth entries (at least 1).
    function automatic int idx_w(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mru_match.sv
// Combinational key lookup over the MRU list; only valid entries can match,
// and the lowest matching index wins.
module mru_match
    import mru_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic [DEPTH*DATA_W-1:0] entries_i,
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [DATA_W-1:0]       key_i,
    output logic                    hit_o,
    output logic [IDX_W-1:0]        hit_idx_o
);

    // Scan from the top down so the lowest matching index is the last writer.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_i[i] && (entries_i[i*DATA_W +: DATA_W] == key_i)) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mru_tracker.sv
// MRU list of the last DEPTH distinct sample values with move-to-front on hit.
// A sample is registered in a stage register, compared against the list in
// the following cycle, and the list/pulses/counters update at that cycle's end.
module mru_tracker
    import mru_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic                    clk_in,
    input  logic                    reset_n_in,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    flush_in,
    output logic [DEPTH*DATA_W-1:0] out_data,
    output logic [DEPTH-1:0]        out_valid,
    output logic                    hit_out,
    output logic                    miss_out,
    output logic [IDX_W-1:0]        hit_idx_out,
    output logic                    evict_valid_out,
    output logic [DATA_W-1:0]       evict_data_out,
    output logic [CNT_W-1:0]        hit_cnt_out,
    output logic [CNT_W-1:0]        miss_cnt_out
);

    logic                    stage_valid_q;
    logic [DATA_W-1:0]       stage_data_q;
    logic [DATA_W-1:0]       entries_q [DEPTH];
    logic [DATA_W-1:0]       entries_d [DEPTH];
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic                    hit_q, hit_d;
    logic                    miss_q, miss_d;
    logic [IDX_W-1:0]        hit_idx_q, hit_idx_d;
    logic                    evict_valid_q, evict_valid_d;
    logic [DATA_W-1:0]       evict_data_q, evict_data_d;
    logic [CNT_W-1:0]        hit_cnt_q, miss_cnt_q;
    logic [DEPTH*DATA_W-1:0] entries_flat;
    logic                    match_hit;
    logic [IDX_W-1:0]        match_idx;

    // Flatten the list for the matcher and the output bus (entry 0 in the low bits).
    always_comb begin
        entries_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_flat[i*DATA_W +: DATA_W] = entries_q[i];
        end
    end

    mru_match #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_match (
        .entries_i (entries_flat),
        .valid_i   (valid_q),
        .key_i     (stage_data_q),
        .hit_o     (match_hit),
        .hit_idx_o (match_idx)
    );

    // Next list contents and event pulses for the staged sample.
    always_comb begin
        entries_d     = entries_q;
        valid_d       = valid_q;
        hit_d         = 1'b0;
        miss_d        = 1'b0;
        hit_idx_d     = hit_idx_q;
        evict_valid_d = 1'b0;
        evict_data_d  = evict_data_q;
        if (stage_valid_q) begin
            if (match_hit) begin
                // Move-to-front: entries above the hit slide down by one.
                hit_d        = 1'b1;
                hit_idx_d    = match_idx;
                entries_d[0] = stage_data_q;
                for (int i = 1; i < DEPTH; i++) begin
                    if (i <= int'(match_idx)) begin
                        entries_d[i] = entries_q[i-1];
                    end
                end
            end else begin
                // Insert at the front; whatever sat in the last slot falls off.
                miss_d       = 1'b1;
                entries_d[0] = stage_data_q;
                for (int i = 1; i < DEPTH; i++) begin
                    entries_d[i] = entries_q[i-1];
                end
                valid_d = {valid_q[DEPTH-2:0], 1'b1};
                if (valid_q[DEPTH-1]) begin
                    evict_valid_d = 1'b1;
                    evict_data_d  = entries_q[DEPTH-1];
                end
            end
        end
    end

    // Stage register, list state, pulses and saturating counters.
    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q       <= '0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            hit_idx_q     <= '0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
        end else if (flush_in) begin
            // Data is kept; only validity and any in-flight sample are dropped.
            stage_valid_q <= 1'b0;
            valid_q       <= '0;
            hit_q         <= 1'b0;
            miss_q        <= 1'b0;
            evict_valid_q <= 1'b0;
        end else begin
            stage_valid_q <= in_valid;
            if (in_valid) begin
                stage_data_q <= data_in;
            end
            entries_q     <= entries_d;
            valid_q       <= valid_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
            hit_idx_q     <= hit_idx_d;
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
            if (hit_d && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (miss_d && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_data        = entries_flat;
    assign out_valid       = valid_q;
    assign hit_out         = hit_q;
    assign miss_out        = miss_q;
    assign hit_idx_out     = hit_idx_q;
    assign evict_valid_out = evict_valid_q;
    assign evict_data_out  = evict_data_q;
    assign hit_cnt_out     = hit_cnt_q;
    assign miss_cnt_out    = miss_cnt_q;

endmodule

// File: tb/tb_mru_tracker.sv
// Directed bench for mru_tracker (DATA_W=8, DEPTH=4, CNT_W=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mru_tracker;

    logic        clk_in = 1'b0;
    logic        reset_n_in;
    logic        in_valid;
    logic [7:0]  data_in;
    logic        flush_in;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic        hit_out;
    logic        miss_out;
    logic [1:0]  hit_idx_out;
    logic        evict_valid_out;
    logic [7:0]  evict_data_out;
    logic [15:0] hit_cnt_out;
    logic [15:0] miss_cnt_out;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk_in = ~clk_in;

    mru_tracker #(
        .DATA_W (8),
        .DEPTH  (4),
        .CNT_W  (16)
    ) dut (
        .clk_in          (clk_in),
        .reset_n_in      (reset_n_in),
        .in_valid        (in_valid),
        .data_in         (data_in),
        .flush_in        (flush_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .hit_out         (hit_out),
        .miss_out        (miss_out),
        .hit_idx_out     (hit_idx_out),
        .evict_valid_out (evict_valid_out),
        .evict_data_out  (evict_data_out),
        .hit_cnt_out     (hit_cnt_out),
        .miss_cnt_out    (miss_cnt_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sample, then idle until its result is visible.
    task automatic send(input logic [7:0] val);
        @(negedge clk_in);
        in_valid = 1'b1;
        data_in  = val;
        @(negedge clk_in);
        in_valid = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_data"},  64'(out_data), 64'h0);
        check({tag, " out_valid"}, 64'(out_valid), 64'h0);
        check({tag, " hit"},       64'(hit_out), 64'h0);
        check({tag, " miss"},      64'(miss_out), 64'h0);
        check({tag, " hit_idx"},   64'(hit_idx_out), 64'h0);
        check({tag, " evict_v"},   64'(evict_valid_out), 64'h0);
        check({tag, " evict_d"},   64'(evict_data_out), 64'h0);
        check({tag, " hit_cnt"},   64'(hit_cnt_out), 64'h0);
        check({tag, " miss_cnt"},  64'(miss_cnt_out), 64'h0);
    endtask

    initial begin
        reset_n_in = 1'b0;
        in_valid   = 1'b0;
        data_in    = 8'h00;
        flush_in   = 1'b0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        reset_n_in = 1'b1;

        // Zero-valued sample misses against an all-invalid, all-zero list.
        send(8'h00);
        check("zero miss",      64'(miss_out), 64'h1);
        check("zero hit",       64'(hit_out), 64'h0);
        check("zero valid",     64'(out_valid), 64'h1);
        check("zero data",      64'(out_data), 64'h0);
        check("zero miss_cnt",  64'(miss_cnt_out), 64'h1);
        @(negedge clk_in);
        check("pulse one cycle", 64'(miss_out), 64'h0);

        // Clear validity so the next four samples fill an empty list.
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        check("flush1 valid", 64'(out_valid), 64'h0);

        // Back-to-back A,B,C,D.
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                check($sformatf("b2b miss %0d", i - 2),  64'(miss_out), 64'h1);
                check($sformatf("b2b evict %0d", i - 2), 64'(evict_valid_out), 64'h0);
            end
            if (i < 4) begin
                in_valid = 1'b1;
                case (i)
                    0: data_in = 8'hA1;
                    1: data_in = 8'hB2;
                    2: data_in = 8'hC3;
                    default: data_in = 8'hD4;
                endcase
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk_in);
        end
        check("b2b data",     64'(out_data), 64'hA1B2C3D4);
        check("b2b valid",    64'(out_valid), 64'hF);
        check("b2b miss_cnt", 64'(miss_cnt_out), 64'd5);
        check("b2b hit_cnt",  64'(hit_cnt_out), 64'd0);

        // Fifth distinct value evicts the oldest.
        send(8'hE5);
        check("evict miss",  64'(miss_out), 64'h1);
        check("evict valid", 64'(evict_valid_out), 64'h1);
        check("evict data",  64'(evict_data_out), 64'hA1);
        check("evict list",  64'(out_data), 64'hB2C3D4E5);
        check("evict mcnt",  64'(miss_cnt_out), 64'd6);
        @(negedge clk_in);
        check("evict pulse gone", 64'(evict_valid_out), 64'h0);

        // Hit in the middle moves to front.
        send(8'hC3);
        check("hit2 hit",   64'(hit_out), 64'h1);
        check("hit2 miss",  64'(miss_out), 64'h0);
        check("hit2 idx",   64'(hit_idx_out), 64'd2);
        check("hit2 list",  64'(out_data), 64'hB2D4E5C3);
        check("hit2 evict", 64'(evict_valid_out), 64'h0);

        // Hit at the front leaves the list alone.
        send(8'hC3);
        check("hit0 hit",  64'(hit_out), 64'h1);
        check("hit0 idx",  64'(hit_idx_out), 64'd0);
        check("hit0 list", 64'(out_data), 64'hB2D4E5C3);
        check("hit0 hcnt", 64'(hit_cnt_out), 64'd2);

        // Flush together with a sample: sample dropped, data retained.
        flush_in = 1'b1;
        in_valid = 1'b1;
        data_in  = 8'h55;
        @(negedge clk_in);
        flush_in = 1'b0;
        in_valid = 1'b0;
        check("flush valid", 64'(out_valid), 64'h0);
        check("flush hit",   64'(hit_out), 64'h0);
        check("flush miss",  64'(miss_out), 64'h0);
        check("flush data",  64'(out_data), 64'hB2D4E5C3);
        @(negedge clk_in);
        check("flush drop miss", 64'(miss_out), 64'h0);
        check("flush drop hit",  64'(hit_out), 64'h0);
        check("flush mcnt",      64'(miss_cnt_out), 64'd6);
        check("flush hcnt",      64'(hit_cnt_out), 64'd2);

        send(8'h55);
        check("post flush miss",  64'(miss_out), 64'h1);
        check("post flush valid", 64'(out_valid), 64'h1);
        check("post flush list",  64'(out_data), 64'hD4E5C355);
        check("post flush evict", 64'(evict_valid_out), 64'h0);
        check("post flush mcnt",  64'(miss_cnt_out), 64'd7);
        check("post flush hcnt",  64'(hit_cnt_out), 64'd2);

        // E5 still sits in an invalid slot; it must not match.
        send(8'hE5);
        check("invalid slot miss",  64'(miss_out), 64'h1);
        check("invalid slot hit",   64'(hit_out), 64'h0);
        check("invalid slot valid", 64'(out_valid), 64'h3);
        check("invalid slot list",  64'(out_data), 64'hE5C355E5);
        check("invalid slot mcnt",  64'(miss_cnt_out), 64'd8);

        // Saturate the hit counter: 65540 consecutive hits on 0x55.
        @(negedge clk_in);
        in_valid = 1'b1;
        data_in  = 8'h55;
        repeat (65540) @(negedge clk_in);
        in_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        check("sat hcnt",  64'(hit_cnt_out), 64'hFFFF);
        check("sat mcnt",  64'(miss_cnt_out), 64'd8);
        check("sat list",  64'(out_data), 64'hE5C3E555);
        check("sat valid", 64'(out_valid), 64'h3);

        // Reset in the middle of a stream drops the in-flight sample.
        in_valid = 1'b1;
        data_in  = 8'h77;
        @(negedge clk_in);
        data_in    = 8'h88;
        reset_n_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("midreset");
        reset_n_in = 1'b1;
        in_valid   = 1'b0;
        repeat (2) @(negedge clk_in);
        check("midreset drop miss", 64'(miss_out), 64'h0);
        check("midreset drop hit",  64'(hit_out), 64'h0);
        check("midreset mcnt",      64'(miss_cnt_out), 64'd0);
        check("midreset valid",     64'(out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
